blit_cmd_queue: RTL and testbench

Command FIFO between the main CPU bus and the blitter command processor. The CPU pushes 32-bit blit command words through a memory-mapped register. The block presents them, first-word-fall-through, on the valid/ready command-queue interface consumed by the blitter's LDCMD instruction. It also exposes status (fill level, full/empty, sticky overflow), a flush control, and a level-sensitive "space available" interrupt.

---
 rtl/blit_cmd_queue.sv | 152 +++++++++++++++
 tb/tb_blit_cmd_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/blit_cmd_queue.sv
// Blitter command queue: CPU-written 32-bit command words presented first-word-fall-through
// on a valid/ready interface, with a STATUS register, flush, sticky overflow and space interrupt.
module blit_cmd_queue #(
   parameter int DEPTH         = 64,
   parameter int LEVEL_W       = $clog2(DEPTH) + 1,
   parameter int IRQ_THRESHOLD = DEPTH / 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cpu_request,
   input  logic        cpu_write,
   input  logic [1:0]  cpu_address,
   input  logic [31:0] cpu_wdata,
   output logic        cpu_ack,
   output logic [31:0] cpu_rdata,
   output logic        cmd_queue_valid,
   output logic [31:0] cmd_queue_data,
   input  logic        cmd_queue_ready,
   output logic        cmd_irq,
   output logic        cmd_empty
);

   // Handshake: a head word transfers on any rising edge where cmd_queue_valid and
   // cmd_queue_ready are both 1; while valid is 1 the data holds until that edge.

   localparam int                 AW        = $clog2(DEPTH);
   localparam logic [LEVEL_W-1:0] DEPTH_L   = LEVEL_W'(DEPTH);
   localparam logic [LEVEL_W-1:0] THRESH_L  = LEVEL_W'(IRQ_THRESHOLD);
   localparam logic [1:0]         ADDR_CMD  = 2'd0;
   localparam logic [1:0]         ADDR_STAT = 2'd1;

   logic [31:0]        mem [DEPTH];
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [LEVEL_W-1:0] count;
   logic               overflow;

   logic               cmd_write;
   logic               status_write;
   logic               status_read;
   logic               flush;
   logic               overflow_clear;
   logic               full;
   logic               empty;
   logic               push;
   logic               push_drop;
   logic               pop;
   logic [LEVEL_W-1:0] ram_words;
   logic               ram_has_word;
   logic               head_free;
   logic               load_from_ram;
   logic               load_bypass;
   logic               ram_write;
   logic [LEVEL_W-1:0] count_next;
   logic [LEVEL_W-1:0] free_next;
   logic [31:0]        status_word;

   always_comb begin
      cmd_write      = cpu_request & cpu_write & (cpu_address == ADDR_CMD);
      status_write   = cpu_request & cpu_write & (cpu_address == ADDR_STAT);
      status_read    = cpu_request & ~cpu_write & (cpu_address == ADDR_STAT);
      flush          = status_write & cpu_wdata[31];
      overflow_clear = status_write & cpu_wdata[18];

      full  = (count == DEPTH_L);
      empty = (count == '0);

      // Room is judged on the start-of-cycle count, so a same-cycle pop never admits a push.
      push      = cmd_write & ~full & ~flush;
      push_drop = cmd_write & full & ~flush;
      pop       = cmd_queue_valid & cmd_queue_ready & ~flush;

      // The RAM holds everything except the word sitting in the output register.
      ram_words     = count - LEVEL_W'(cmd_queue_valid);
      ram_has_word  = (ram_words != '0);
      head_free     = ~cmd_queue_valid | pop;
      load_from_ram = head_free & ram_has_word;
      load_bypass   = head_free & ~ram_has_word & push;
      ram_write     = push & ~load_bypass;

      if (flush) begin
         count_next = '0;
      end else begin
         count_next = count + LEVEL_W'(push) - LEVEL_W'(pop);
      end
      free_next = DEPTH_L - count_next;

      status_word = {13'd0, overflow, full, empty, 16'(count)};
   end

   always_ff @(posedge clock) begin
      if (reset && ram_write) begin
         mem[wr_ptr] <= cpu_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         cmd_queue_valid <= 1'b0;
         cmd_queue_data  <= '0;
      end else if (flush) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         cmd_queue_valid <= 1'b0;
      end else begin
         count <= count_next;
         if (ram_write) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (load_from_ram) begin
            cmd_queue_data  <= mem[rd_ptr];
            cmd_queue_valid <= 1'b1;
            rd_ptr          <= rd_ptr + 1'b1;
         end else if (load_bypass) begin
            cmd_queue_data  <= cpu_wdata;
            cmd_queue_valid <= 1'b1;
         end else if (head_free) begin
            cmd_queue_valid <= 1'b0;
         end
      end
   end

   // A drop in the same cycle as a clear wins, so no overflow event is ever lost.
   always_ff @(posedge clock) begin
      if (!reset) begin
         overflow <= 1'b0;
      end else if (push_drop) begin
         overflow <= 1'b1;
      end else if (overflow_clear) begin
         overflow <= 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cpu_ack   <= 1'b0;
         cpu_rdata <= '0;
         cmd_empty <= 1'b1;
         cmd_irq   <= 1'b1;
      end else begin
         cpu_ack   <= cpu_request;
         cpu_rdata <= status_read ? status_word : 32'd0;
         cmd_empty <= (count_next == '0);
         cmd_irq   <= (free_next >= THRESH_L);
      end
   end

endmodule

// File: tb/tb_blit_cmd_queue.sv
// Self-checking bench for blit_cmd_queue: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_blit_cmd_queue;

   localparam int DEPTH  = 64;
   localparam int THRESH = DEPTH / 2;

   logic        clock;
   logic        reset;
   logic        cpu_request;
   logic        cpu_write;
   logic [1:0]  cpu_address;
   logic [31:0] cpu_wdata;
   logic        cpu_ack;
   logic [31:0] cpu_rdata;
   logic        cmd_queue_valid;
   logic [31:0] cmd_queue_data;
   logic        cmd_queue_ready;
   logic        cmd_irq;
   logic        cmd_empty;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   blit_cmd_queue #(.DEPTH(DEPTH)) dut (
      .clock           (clock),
      .reset           (reset),
      .cpu_request     (cpu_request),
      .cpu_write       (cpu_write),
      .cpu_address     (cpu_address),
      .cpu_wdata       (cpu_wdata),
      .cpu_ack         (cpu_ack),
      .cpu_rdata       (cpu_rdata),
      .cmd_queue_valid (cmd_queue_valid),
      .cmd_queue_data  (cmd_queue_data),
      .cmd_queue_ready (cmd_queue_ready),
      .cmd_irq         (cmd_irq),
      .cmd_empty       (cmd_empty)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: contents as a plain queue, overflow flag, expected bus reply
   logic [31:0] exp_q[$];
   logic        m_ovf;
   logic        m_full;
   logic        m_flush;
   logic        m_push;
   logic        exp_ack;
   logic [31:0] exp_rdata;

   always @(posedge clock) begin
      if (!reset) begin
         exp_q.delete();
         m_ovf     = 1'b0;
         exp_ack   = 1'b0;
         exp_rdata = 32'd0;
      end else begin
         m_full    = (exp_q.size() == DEPTH);
         exp_ack   = cpu_request;
         exp_rdata = (cpu_request && !cpu_write && cpu_address == 2'd1) ?
                     {13'd0, m_ovf, m_full, exp_q.size() == 0, 16'(exp_q.size())} : 32'd0;
         m_flush   = cpu_request && cpu_write && cpu_address == 2'd1 && cpu_wdata[31];
         m_push    = cpu_request && cpu_write && cpu_address == 2'd0;
         if (m_flush) begin
            exp_q.delete();
            if (cpu_wdata[18]) m_ovf = 1'b0;
         end else begin
            if (exp_q.size() > 0 && cmd_queue_ready) void'(exp_q.pop_front());
            if (m_push && !m_full) exp_q.push_back(cpu_wdata);
            if (m_push && m_full) m_ovf = 1'b1;
            else if (cpu_request && cpu_write && cpu_address == 2'd1 && cpu_wdata[18]) m_ovf = 1'b0;
         end
      end
   end

   // scoreboard compare, every cycle after the first reset
   always @(negedge clock) begin
      if (chk_en) begin
         check("valid", {31'd0, cmd_queue_valid}, {31'd0, exp_q.size() != 0});
         if (exp_q.size() != 0) check("data", cmd_queue_data, exp_q[0]);
         check("empty", {31'd0, cmd_empty}, {31'd0, exp_q.size() == 0});
         check("irq", {31'd0, cmd_irq}, {31'd0, (DEPTH - exp_q.size()) >= THRESH});
         check("ack", {31'd0, cpu_ack}, {31'd0, exp_ack});
         check("rdata", cpu_rdata, exp_rdata);
      end
   end

   // driver tasks: each call drives one cycle and returns at the following negedge
   task automatic bus(input logic req, input logic wr, input logic [1:0] a,
                      input logic [31:0] d, input logic rdy);
      cpu_request     = req;
      cpu_write       = wr;
      cpu_address     = a;
      cpu_wdata       = d;
      cmd_queue_ready = rdy;
      @(negedge clock);
   endtask

   task automatic idle(input logic rdy);
      bus(1'b0, 1'b0, 2'd0, 32'd0, rdy);
   endtask

   task automatic push(input logic [31:0] d, input logic rdy);
      bus(1'b1, 1'b1, 2'd0, d, rdy);
   endtask

   task automatic write_status(input logic [31:0] d, input logic rdy);
      bus(1'b1, 1'b1, 2'd1, d, rdy);
   endtask

   task automatic read_status(output logic [31:0] v);
      bus(1'b1, 1'b0, 2'd1, 32'd0, 1'b0);
      v = cpu_rdata;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      idle(1'b0);
      reset = 1'b1;
   endtask

   logic [31:0] st;
   logic [31:0] w0;
   int          r;

   initial begin
      reset = 1'b0;
      cpu_request = 0; cpu_write = 0; cpu_address = 0; cpu_wdata = 0; cmd_queue_ready = 0;
      @(negedge clock);
      idle(1'b0);
      reset = 1'b1;
      chk_en = 1;
      check("rst_valid", {31'd0, cmd_queue_valid}, 32'd0);
      check("rst_data", cmd_queue_data, 32'd0);
      check("rst_empty", {31'd0, cmd_empty}, 32'd1);
      check("rst_irq", {31'd0, cmd_irq}, 32'd1);
      check("rst_ack", {31'd0, cpu_ack}, 32'd0);

      // single push into empty queue
      push(32'h0000_0011, 1'b0);
      check("p1_valid", {31'd0, cmd_queue_valid}, 32'd1);
      check("p1_data", cmd_queue_data, 32'h11);
      check("p1_empty", {31'd0, cmd_empty}, 32'd0);
      check("p1_irq", {31'd0, cmd_irq}, 32'd1);
      read_status(st);
      check("p1_status", st, 32'h0000_0001);

      // fill to full, overflow with a simultaneous pop, drain
      write_status(32'h8000_0000, 1'b0);
      for (int i = 0; i < DEPTH; i++) push(i, 1'b0);
      check("full_irq", {31'd0, cmd_irq}, 32'd0);
      read_status(st);
      check("full_status", st, 32'h0002_0040);
      push(32'h0000_DEAD, 1'b1);
      check("ovf_head", cmd_queue_data, 32'd1);
      read_status(st);
      check("ovf_status", st, 32'h0004_003F);
      for (int n = 0; n < 2 * DEPTH && cmd_queue_valid; n++) idle(1'b1);
      check("drain_empty", {31'd0, cmd_empty}, 32'd1);
      write_status(32'h0004_0000, 1'b0);
      read_status(st);
      check("ovf_clear", st, 32'h0001_0000);

      // streaming: push and pop every cycle, pointers wrap several times
      w0 = $urandom;
      push(w0, 1'b1);
      check("stream_first", cmd_queue_data, w0);
      for (int i = 0; i < 199; i++) push($urandom, 1'b1);
      idle(1'b1);
      check("stream_end_empty", {31'd0, cmd_empty}, 32'd1);

      // flush beats a pop in the same cycle
      for (int i = 0; i < 10; i++) push(32'h100 + i, 1'b0);
      write_status(32'h8000_0000, 1'b1);
      check("flush_valid", {31'd0, cmd_queue_valid}, 32'd0);
      read_status(st);
      check("flush_status", st, 32'h0001_0000);
      push(32'h0000_0ABC, 1'b0);
      check("flush_next_head", cmd_queue_data, 32'h0000_0ABC);

      // reset mid-burst, then irq threshold crossing
      for (int i = 0; i < 39; i++) push($urandom, 1'b0);
      pulse_reset();
      check("mid_rst_valid", {31'd0, cmd_queue_valid}, 32'd0);
      check("mid_rst_data", cmd_queue_data, 32'd0);
      check("mid_rst_irq", {31'd0, cmd_irq}, 32'd1);
      read_status(st);
      check("mid_rst_status", st, 32'h0001_0000);
      for (int i = 0; i < 32; i++) push(32'h200 + i, 1'b0);
      check("irq_at_32", {31'd0, cmd_irq}, 32'd1);
      push(32'h220, 1'b0);
      check("irq_at_33", {31'd0, cmd_irq}, 32'd0);
      idle(1'b1);
      check("irq_back_32", {31'd0, cmd_irq}, 32'd1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         reset = ($urandom_range(0, 499) != 0);
         r = $urandom_range(0, 10);
         case (r)
            0, 1, 2, 3, 4, 5: push($urandom, $urandom_range(0, 9) < 4);
            6: bus(1'b1, 1'b0, 2'd1, $urandom, $urandom_range(0, 1));
            7: write_status({$urandom_range(0, 7) == 0, 12'd0, 1'($urandom), 18'($urandom)},
                            $urandom_range(0, 1));
            8: bus(1'b1, 1'b0, 2'($urandom_range(0, 3) & 2'd2), $urandom, $urandom_range(0, 1));
            9: bus(1'b1, 1'b1, 2'($urandom_range(2, 3)), $urandom, $urandom_range(0, 1));
            default: idle($urandom_range(0, 1));
         endcase
      end
      reset = 1'b1;
      idle(1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
